mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares the core's single instruction/data memory port between the instruction-fetch unit and the load/store path driven by the control unit. Request side uses a req/gnt handshake and response side uses an in-order rvalid handshake. The block arbitrates each transaction, holds the selected request stable until it is granted, and tracks outstanding transactions. It routes each response back to the requester that issued it.

## Interface
- MAX_OUTSTANDING, 2: maximum accepted-but-unanswered memory transactions (1..4).
- clk  in  1  core clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  32  fetch word address.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch response valid; data on rdata.
- d_req  in  1  load/store request; held until d_gnt.
- d_we  in  1  1 = store.
- d_be  in  4  byte enables.
- d_addr  in  32  data address.
- d_wdata  in  32  store data.
- d_gnt  out  1  data request accepted.
- d_rvalid  out  1  data response valid (loads and stores).
- rdata  out  32  mem_rdata, broadcast to both requesters.
- mem_req  out  1  request to memory.
- mem_we, mem_be, mem_addr, mem_wdata  out  1/4/32/32  muxed request fields; fetch drives we=0, be=4'hF, wdata=0.
- mem_gnt  in  1  memory accepted mem_req.
- mem_rvalid  in  1  in-order response valid.
- mem_rdata  in  32  response data.
- resp_err  out  1  sticky: mem_rvalid seen with no outstanding transaction.

## Operation
- Controller states:
  - IDLE: no request is presented.
  - WAIT_GNT: mem_req is high and not yet granted; owner is locked.
- IDLE arbitration:
  - If any request is active and outstanding count < MAX_OUTSTANDING, select an owner.
  - Drive mem_req=1 with the owner's fields.
  - If mem_gnt=1 the same cycle, stay in IDLE. Otherwise go to WAIT_GNT with the owner latched.
- Policy: fixed priority, data over fetch.
- WAIT_GNT:
  - The latched owner's fields drive the port, even if the other requester now has priority.
  - On mem_gnt, return to IDLE.
- Grant routing: if_gnt = mem_gnt & mem_req & owner==IF. d_gnt is the same with owner==D.
- Owner FIFO:
  - On each grant, push the owner onto an owner FIFO of depth MAX_OUTSTANDING.
  - On mem_rvalid, pop the head and assert if_rvalid or d_rvalid for that cycle.
- Full FIFO: when count == MAX_OUTSTANDING, mem_req is 0 in IDLE. There is no bypass for a same-cycle pop. A request already in WAIT_GNT stays presented, because the FIFO slot is checked at issue.
- Simultaneous grant and rvalid: push and pop in the same cycle; count is unchanged.
- mem_rvalid with empty FIFO: no rvalid is routed, resp_err is set, count stays 0 (no underflow).
- Reset values: state IDLE, count 0, FIFO pointers 0, resp_err 0, RR pointer = IF.
- While rst is high, mem_req, if_gnt, d_gnt, if_rvalid and d_rvalid are forced to 0.
- Reset mid-transaction discards outstanding ownership. Memory is reset with the core.

## Timing
- Request path is combinational: req to mem_req, and mem_gnt to if_gnt/d_gnt, with zero added latency.
- Response path is combinational: mem_rvalid to if_rvalid/d_rvalid in the same cycle.
- Back-to-back throughput: one grant per cycle while count < MAX_OUTSTANDING and mem_gnt=1.
- A new owner decision never changes mem_addr while mem_req=1 and mem_gnt=0.
- Count and FIFO update on the clock edge after the grant or response.

## Configuration
- MEM_ARB_RR_EN defined: round-robin policy. A 1-bit last-granted register gives priority to the requester not granted last. It updates only on a grant.
- MEM_ARB_RR_EN undefined: fixed priority, data over fetch. No pointer register.

## Structure
- Package rv32_pkg holds:
  - typedef enum logic {OWN_IF, OWN_D} arb_owner_e
  - typedef enum logic {ARB_IDLE, ARB_WAIT_GNT} arb_state_e
  - localparam MEM_ARB_MAX_OUT_LIMIT = 4
- Sub-module arb_owner_fifo: a parameterised depth-N FIFO of arb_owner_e with push, pop, full, empty, count and head. It is instantiated once.

## Test plan
- Both requests active, mem_gnt=1 every cycle, MAX_OUTSTANDING=2, rvalid 1 cycle after each grant:
  - Fixed priority: d_gnt on every cycle while d_req is held, and if_gnt=0 throughout.
  - With MEM_ARB_RR_EN: grants alternate D, IF, D, IF.
- if_req alone with mem_gnt low for 3 cycles; d_req rises in cycle 2 → mem_addr equals if_addr for all 3 cycles. if_gnt occurs in cycle 4, then d is granted next.
- Issue 2 grants with no rvalid → mem_req=0 while count=2. Send 1 rvalid → head owner's rvalid pulses and the next request is presented the following cycle.
- Grant IF at 0x100, then D load at 0x200; return rvalid twice with rdata 0xAAAA_0001 then 0xBBBB_0002 → if_rvalid with 0xAAAA_0001, then d_rvalid with 0xBBBB_0002.
- mem_rvalid=1 with count=0 → resp_err=1, no rvalid routed, count=0. Assert rst → resp_err=0.
- Assert rst with count=1 in WAIT_GNT → state IDLE, count 0, and all outputs 0 during reset.

Source files
------------

// File: rtl/rv32_pkg.sv
// Shared types for the core's memory-port arbiter.
package rv32_pkg;

  typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} arb_owner_e;
  typedef enum logic {ARB_IDLE = 1'b0, ARB_WAIT_GNT = 1'b1} arb_state_e;

  localparam int MEM_ARB_MAX_OUT_LIMIT = 4;

  // Clamp a requested outstanding depth into the supported 1..limit range.
  function automatic int arb_depth(input int n);
    if (n < 1) return 1;
    if (n > MEM_ARB_MAX_OUT_LIMIT) return MEM_ARB_MAX_OUT_LIMIT;
    return n;
  endfunction

endpackage

// File: rtl/arb_owner_fifo.sv
// Owner FIFO: remembers which requester issued each in-flight memory
// transaction so in-order responses can be routed back. DEPTH is 1..4.
module arb_owner_fifo
  import rv32_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  arb_owner_e push_owner,
  input  logic       pop,
  output logic       full,
  output logic       empty,
  output logic [2:0] count,
  output arb_owner_e head
);

  // Storage is sized to the package limit so the 2-bit pointers always fit;
  // only the first DEPTH entries are ever used.
  arb_owner_e r_mem [MEM_ARB_MAX_OUT_LIMIT];
  logic [1:0] r_wr_ptr;
  logic [1:0] r_rd_ptr;
  logic [2:0] r_count;
  logic       w_push;
  logic       w_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'(DEPTH - 1)) ? 2'd0 : p + 2'd1;
  endfunction

  assign w_pop  = pop & (r_count != 3'd0);
  assign w_push = push & ((r_count != 3'(DEPTH)) | w_pop);

  assign full  = (r_count == 3'(DEPTH));
  assign empty = (r_count == 3'd0);
  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

  // Write the pushed owner into the slot at the write pointer.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= push_owner;
  end

  // Advance pointers and occupancy; push+pop together leaves count unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 3'd0;
    end else begin
      if (w_push) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
      if (w_push && !w_pop)      r_count <= r_count + 3'd1;
      else if (w_pop && !w_push) r_count <= r_count - 3'd1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between instruction fetch and load/store.
// Build option MEM_ARB_RR_EN: round-robin instead of data-over-fetch priority.
module mem_arbiter
  import rv32_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_err
);

  localparam int DEPTH = arb_depth(MAX_OUTSTANDING);

  arb_state_e r_state;
  arb_owner_e r_owner;
  logic       r_err;
  arb_owner_e w_sel;
  arb_owner_e w_owner;
  arb_owner_e w_head;
  logic       w_full;
  logic       w_empty;
  logic [2:0] w_count;
  logic       w_issue;
  logic       w_req;
  logic       w_grant;
  logic       w_pop;
  logic       w_unused;

`ifdef MEM_ARB_RR_EN
  arb_owner_e r_last;

  // Round-robin pick: on contention, favour whoever was not granted last.
  always_comb begin
    if (d_req && if_req) w_sel = (r_last == OWN_D) ? OWN_IF : OWN_D;
    else if (d_req)      w_sel = OWN_D;
    else                 w_sel = OWN_IF;
  end

  // Remember the last granted requester; only a real grant moves it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          r_last <= OWN_IF;
    else if (w_grant) r_last <= w_owner;
  end
`else
  assign w_sel = d_req ? OWN_D : OWN_IF;
`endif

  // A new issue needs a free FIFO slot; a locked request was checked at issue.
  assign w_issue = (if_req | d_req) & ~w_full;
  assign w_req   = (r_state == ARB_WAIT_GNT) | w_issue;
  assign w_owner = (r_state == ARB_WAIT_GNT) ? r_owner : w_sel;

  assign mem_req = w_req & ~rst;
  assign w_grant = mem_req & mem_gnt;
  assign if_gnt  = w_grant & (w_owner == OWN_IF);
  assign d_gnt   = w_grant & (w_owner == OWN_D);

  // No same-cycle bypass: a response with an empty FIFO is an error, not a pop.
  assign w_pop     = mem_rvalid & ~w_empty & ~rst;
  assign if_rvalid = w_pop & (w_head == OWN_IF);
  assign d_rvalid  = w_pop & (w_head == OWN_D);
  assign rdata     = mem_rdata;
  assign resp_err  = r_err;

  // Occupancy is available on the FIFO for debug taps but not needed here.
  assign w_unused = &{1'b0, w_count};

  // Steer the owning requester's fields onto the memory port.
  always_comb begin
    if (w_owner == OWN_D) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else begin
      mem_we    = 1'b0;
      mem_be    = 4'hF;
      mem_addr  = if_addr;
      mem_wdata = 32'd0;
    end
  end

  // Lock the owner while a presented request waits for mem_gnt.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
      r_owner <= OWN_IF;
    end else if (r_state == ARB_IDLE) begin
      if (w_req && !mem_gnt) begin
        r_state <= ARB_WAIT_GNT;
        r_owner <= w_sel;
      end
    end else if (mem_gnt) begin
      r_state <= ARB_IDLE;
    end
  end

  // Sticky flag for a response that arrives with nothing outstanding.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        r_err <= 1'b0;
    else if (mem_rvalid && w_empty) r_err <= 1'b1;
  end

  arb_owner_fifo #(
    .DEPTH(DEPTH)
  ) u_owner_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_grant),
    .push_owner(w_owner),
    .pop       (w_pop),
    .full      (w_full),
    .empty     (w_empty),
    .count     (w_count),
    .head      (w_head)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter with a transaction-level reference model
// and a scoreboard; honours MEM_ARB_RR_EN for the expected policy.
module tb_mem_arbiter;

  localparam int MAXO = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, mem_gnt, mem_rvalid;
  logic [31:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic        if_gnt, if_rvalid, d_gnt, d_rvalid, resp_err;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] rdata, mem_addr, mem_wdata;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_OUTSTANDING(MAXO)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .rdata(rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .resp_err(resp_err)
  );

  typedef struct {
    bit          req, ifg, dg, ifrv, drv, err, we;
    logic [31:0] addr, wd;
    logic [3:0]  be;
  } cyc_t;
  typedef struct {
    bit          is_d;
    logic [31:0] data;
  } rsp_t;

  cyc_t cyc_q[$];
  rsp_t rsp_q[$];
  int   checks = 0;
  int   failures = 0;

  // Reference model: list of in-flight owners (0=fetch, 1=data), lock, policy.
  int out_q[$];
  bit locked, last_d, m_err;
  int lock_own;
  bit p_grant, p_pop, p_req, p_erv, p_rst;
  int p_own;
  // Stimulus knobs.
  int p_if, p_d, p_gnt, p_rv, rv_mode;
  bit rst_k;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", n, act, exp, $time);
    end
  endtask

  function automatic int pick();
`ifdef MEM_ARB_RR_EN
    if (if_req && d_req) return last_d ? 0 : 1;
`endif
    return d_req ? 1 : 0;
  endfunction

  task automatic step();
    cyc_t c;
    bit   ereq, g_if, g_d;
    int   own;
    @(posedge clk);
    g_if = 0;
    g_d  = 0;
    if (p_rst) begin
      out_q.delete();
      locked = 0;
      last_d = 0;
      m_err  = 0;
    end else begin
      if (p_pop) void'(out_q.pop_front());
      if (p_grant) begin
        out_q.push_back(p_own);
        last_d = (p_own == 1);
        locked = 0;
        if (p_own == 1) g_d = 1; else g_if = 1;
      end else if (p_req) begin
        locked   = 1;
        lock_own = p_own;
      end
      if (p_erv) m_err = 1;
    end
    #1;
    rst = rst_k;
    if (rst_k) begin
      if_req = 0;
      d_req  = 0;
    end else begin
      if (g_if) if_req = 0;
      if (g_d)  d_req  = 0;
      if (!if_req && $urandom_range(99) < p_if) begin
        if_req  = 1;
        if_addr = $urandom;
      end
      if (!d_req && $urandom_range(99) < p_d) begin
        d_req   = 1;
        d_we    = 1'($urandom_range(1));
        d_be    = 4'($urandom);
        d_addr  = $urandom;
        d_wdata = $urandom;
      end
    end
    mem_gnt   = ($urandom_range(99) < p_gnt);
    mem_rdata = $urandom;
    if (rst_k)             mem_rvalid = 0;
    else if (rv_mode == 1) mem_rvalid = p_grant;
    else if (rv_mode == 2) mem_rvalid = 1;
    else                   mem_rvalid = (out_q.size() > 0) && ($urandom_range(99) < p_rv);

    c = '{default: 0};
    p_grant = 0; p_pop = 0; p_req = 0; p_erv = 0;
    if (!rst_k) begin
      ereq = 0;
      own  = 0;
      if (locked) begin
        ereq = 1;
        own  = lock_own;
      end else if ((if_req || d_req) && out_q.size() < MAXO) begin
        ereq = 1;
        own  = pick();
      end
      c.req = ereq;
      c.ifg = ereq && mem_gnt && own == 0;
      c.dg  = ereq && mem_gnt && own == 1;
      if (own == 1) begin
        c.addr = d_addr; c.we = d_we; c.be = d_be; c.wd = d_wdata;
      end else begin
        c.addr = if_addr; c.we = 0; c.be = 4'hF; c.wd = 32'd0;
      end
      c.err = m_err;
      if (mem_rvalid) begin
        if (out_q.size() > 0) begin
          p_pop  = 1;
          c.ifrv = (out_q[0] == 0);
          c.drv  = (out_q[0] == 1);
          rsp_q.push_back('{out_q[0] == 1, mem_rdata});
        end else begin
          p_erv = 1;
        end
      end
      p_grant = ereq && mem_gnt;
      p_own   = own;
      p_req   = ereq;
    end
    p_rst = rst_k;
    cyc_q.push_back(c);
  endtask

  // Monitor: compares every presented cycle against the scoreboard entries.
  always @(negedge clk) begin : monitor
    cyc_t c;
    rsp_t r;
    if (cyc_q.size() > 0) begin
      c = cyc_q.pop_front();
      chk("mem_req", mem_req, c.req);
      chk("if_gnt", if_gnt, c.ifg);
      chk("d_gnt", d_gnt, c.dg);
      chk("if_rvalid", if_rvalid, c.ifrv);
      chk("d_rvalid", d_rvalid, c.drv);
      chk("resp_err", resp_err, c.err);
      if (c.req) begin
        chk("mem_addr", mem_addr, c.addr);
        chk("mem_we", mem_we, c.we);
        chk("mem_be", mem_be, c.be);
        chk("mem_wdata", mem_wdata, c.wd);
      end
      if (if_rvalid || d_rvalid) begin
        if (rsp_q.size() == 0) begin
          chk("rsp_unexpected", 1, 0);
        end else begin
          r = rsp_q.pop_front();
          chk("rsp_owner_is_d", d_rvalid, r.is_d);
          chk("rsp_rdata", rdata, r.data);
        end
      end
    end
  end

  initial begin
    rst = 1; if_req = 0; d_req = 0; d_we = 0; d_be = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    p_rst = 1; rst_k = 1; p_grant = 0; p_pop = 0; p_req = 0; p_erv = 0; p_own = 0;
    p_if = 0; p_d = 0; p_gnt = 0; p_rv = 0; rv_mode = 0;
    locked = 0; last_d = 0; m_err = 0; lock_own = 0;
    repeat (3) step();
    rst_k = 0;
    // Saturated: both requesting, memory always grants, response next cycle.
    p_if = 100; p_d = 100; p_gnt = 100; rv_mode = 1;
    repeat (20) step();
    // Memory stalls: presented request must stay locked.
    p_gnt = 0; rv_mode = 0; p_rv = 50;
    repeat (6) step();
    // General random traffic, including FIFO-full back-pressure.
    p_if = 50; p_d = 50; p_gnt = 50; p_rv = 40;
    repeat (400) step();
    // Drain, then a stray response with nothing outstanding.
    p_if = 0; p_d = 0; p_gnt = 100; p_rv = 100;
    repeat (12) step();
    rv_mode = 2; step(); rv_mode = 0;
    repeat (3) step();
    rst_k = 1; repeat (2) step(); rst_k = 0;
    // Reset while one transaction is outstanding and another waits for grant.
    p_if = 100; p_d = 0; p_gnt = 100; p_rv = 0;
    step();
    p_gnt = 0;
    repeat (3) step();
    rst_k = 1; repeat (2) step(); rst_k = 0;
    p_if = 60; p_d = 60; p_gnt = 70; p_rv = 50;
    repeat (300) step();
    p_if = 0; p_d = 0; p_gnt = 100; p_rv = 100;
    repeat (12) step();
    @(negedge clk);
    #1;
    chk("rsp_queue_drained", rsp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
